// File: rtl/uart_tx_queue.sv
// Two-source byte queue and single driver of the uart_tx start/data pair.
// Define UART_TXQ_NEWLINE_EN to follow every queued byte with 8'h0A.
module uart_tx_queue #(
   parameter int DEPTH     = 8,
   parameter int BUSY_WAIT = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     evt_valid,
   input  logic [7:0]               evt_data,
   input  logic                     pos_valid,
   input  logic [7:0]               pos_data,
   input  logic                     flush,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = CW + 1;
   localparam int WW = $clog2(BUSY_WAIT + 1);

`ifdef UART_TXQ_NEWLINE_EN
   typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, NL_SEND} state_t;
`else
   typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;
`endif

   state_t state, state_d;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [FW-1:0] free;
   logic [1:0]    n_push;
   logic          pop, evt_acc, pos_acc, drop;
   logic [WW-1:0] wcnt, wcnt_d;
   logic          start_d, ld_head, done;
`ifdef UART_TXQ_NEWLINE_EN
   logic          ld_nl, nl_phase;
`endif

   assign full  = (fifo_count == CW'(DEPTH));
   assign empty = (fifo_count == '0);
   assign pop   = (state == IDLE) && !empty && !tx_busy;

   // A same-cycle pop frees a slot for the push
   always_comb begin
      free    = FW'(DEPTH) - {1'b0, fifo_count} + FW'(pop);
      evt_acc = evt_valid && (free >= FW'(1));
      pos_acc = pos_valid &&
                (free >= (evt_valid ? FW'(2) : FW'(1)));
      drop    = (evt_valid && !evt_acc) ||
                (pos_valid && !pos_acc);
      n_push  = {1'b0, evt_acc} + {1'b0, pos_acc};
   end

   always_ff @(posedge clock) begin
      if (!flush) begin
         if (evt_acc) mem[wr_ptr] <= evt_data;
         if (pos_acc) mem[wr_ptr + AW'(evt_acc)] <= pos_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr + AW'(n_push);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count + CW'(n_push) - CW'(pop);
         if (drop) overflow <= 1'b1;
      end
   end

   always_comb begin
      state_d = state;
      wcnt_d  = wcnt;
      start_d = 1'b0;
      ld_head = 1'b0;
      done    = 1'b0;
`ifdef UART_TXQ_NEWLINE_EN
      ld_nl   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (pop) begin
               start_d = 1'b1;
               ld_head = 1'b1;
               wcnt_d  = '0;
               state_d = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (tx_busy) state_d = WAIT_LO;
            else if (wcnt == WW'(BUSY_WAIT)) done = 1'b1;
            else wcnt_d = wcnt + WW'(1);
         end
         WAIT_LO: begin
            if (!tx_busy) done = 1'b1;
         end
`ifdef UART_TXQ_NEWLINE_EN
         NL_SEND: begin
            if (!tx_busy) begin
               start_d = 1'b1;
               ld_nl   = 1'b1;
               wcnt_d  = '0;
               state_d = WAIT_HI;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      if (done) begin
`ifdef UART_TXQ_NEWLINE_EN
         state_d = nl_phase ? IDLE : NL_SEND;
`else
         state_d = IDLE;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wcnt     <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         state    <= state_d;
         wcnt     <= wcnt_d;
         tx_start <= start_d;
         if (ld_head) tx_data <= mem[rd_ptr];
`ifdef UART_TXQ_NEWLINE_EN
         else if (ld_nl) tx_data <= 8'h0A;
`endif
      end
   end

`ifdef UART_TXQ_NEWLINE_EN
   // Marks that the transfer in flight is the trailing newline
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) nl_phase <= 1'b0;
      else if (ld_nl) nl_phase <= 1'b1;
      else if (done) nl_phase <= 1'b0;
   end
`endif

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte queue and arbiter placed directly upstream of uart_tx. It is the single driver of tx_start and tx_data.
- Accepts one-cycle byte requests from two game-side sources:
  - event channel, high priority: start/game-over codes such as 'R'.
  - position channel: mole index '0'..'4'.
- Buffers the bytes in a FIFO and sends them one at a time through the tx_start/tx_busy handshake.
- This removes the multiple-driver and lost-byte hazards on the UART transmit path.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, minimum 2.
- BUSY_WAIT, 4, clock cycles allowed after tx_start for tx_busy to rise before the byte is treated as sent.

Ports:
- clock  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- evt_valid  input  1  one-cycle request to enqueue evt_data (high priority).
- evt_data  input  8  event byte.
- pos_valid  input  1  one-cycle request to enqueue pos_data.
- pos_data  input  8  position byte.
- flush  input  1  synchronous clear of the FIFO and the overflow flag.
- tx_busy  input  1  busy flag from uart_tx.
- tx_start  output  1  one-cycle start pulse to uart_tx.
- tx_data  output  8  byte presented to uart_tx; held stable from the tx_start cycle until the transfer completes.
- fifo_count  output  $clog2(DEPTH)+1  number of occupied entries.
- full  output  1  fifo_count == DEPTH.
- empty  output  1  fifo_count == 0.
- overflow  output  1  sticky flag: a request was dropped.

Behaviour:
- Reset (reset low, asynchronous):
  - tx_start=0, tx_data=8'h00, fifo_count=0, empty=1, full=0, overflow=0.
  - Read/write pointers are 0 and the FSM is in IDLE.
  - Reset mid-transfer abandons the byte. tx_start never glitches high during reset.
- Enqueue, evaluated each cycle, using free = DEPTH - fifo_count plus any slot the same-cycle pop frees:
  - Both requests valid and free>=2: write evt_data, then pos_data. Both become visible on the next cycle, evt first.
  - Both requests valid and free==1: write evt only, drop pos, set overflow.
  - Any request with free==0: drop it and set overflow.
  - overflow stays set until flush or reset.
- Pop and push in the same cycle: permitted. A pop frees a slot usable by the same-cycle push, so a full FIFO plus pop plus one push stays full with nothing dropped. fifo_count = old + pushes - pops.
- Pointers: width $clog2(DEPTH) and wrap modulo DEPTH.
- full and empty: derived from the registered fifo_count.
- flush: synchronous, and has priority over same-cycle enqueues, which are discarded without setting overflow.
  - Clears the pointers, fifo_count and overflow.
  - Does not abort an in-flight byte: the FSM finishes its current transfer normally.
- TX FSM:
  - IDLE: if not empty and tx_busy==0, pop the head into tx_data, pulse tx_start=1 for exactly 1 cycle, go to WAIT_HI with a wait counter of 0.
  - WAIT_HI:
    - If tx_busy==1, go to WAIT_LO.
    - Otherwise increment the counter; when it reaches BUSY_WAIT, go to IDLE (byte considered sent).
  - WAIT_LO: when tx_busy==0, go to IDLE.
  - Never pulse tx_start while tx_busy==1 or outside IDLE.
- Latency: a byte pushed into an empty FIFO while the FSM is in IDLE and tx_busy=0 produces tx_start 2 cycles after the valid pulse (1 cycle write, 1 cycle IDLE pop).
- Back-to-back bytes: minimum one IDLE cycle between tx_busy falling and the next tx_start.
- Order: strictly FIFO. Priority applies only to same-cycle arbitration and to drop selection.

Optional Feature:
- Macro: UART_TXQ_NEWLINE_EN.
- Defined:
  - After each queued byte completes (WAIT_HI timeout or WAIT_LO exit), the FSM enters NL_SEND and transmits 8'h0A with the same handshake before returning to IDLE.
  - The newline occupies no FIFO entry and does not change fifo_count.
  - flush does not suppress a pending newline.
- Undefined: NL_SEND is absent; only queued bytes are transmitted.

Test Plan:
- Reset, then a single pos_valid with pos_data=8'h32 ('2'), tx_busy modelled as 1 from the cycle after tx_start for 10 cycles:
  - tx_start pulses once, 2 cycles after pos_valid, with tx_data=8'h32.
  - empty returns to 1.
- evt_valid with 'R' (8'h52) and pos_valid with '3' (8'h33) in the same cycle: bytes go out in the order 8'h52 then 8'h33, two tx_start pulses, each issued only after tx_busy has fallen.
- Hold tx_busy=1 and push 9 position bytes with DEPTH=8:
  - full=1, fifo_count=8, overflow=1 after the 9th push.
  - After tx_busy is released, exactly 8 bytes are sent in push order.
- tx_busy held at 0 permanently: each byte still completes via the BUSY_WAIT timeout, so 3 queued bytes produce 3 tx_start pulses spaced BUSY_WAIT+2 cycles apart.
- flush during an active transfer with 4 entries queued:
  - The current byte completes.
  - fifo_count=0 and overflow=0 the cycle after flush; no further tx_start.
- Assert reset low mid-WAIT_LO: tx_start=0, tx_data=8'h00 and empty=1 immediately (asynchronously). With UART_TXQ_NEWLINE_EN, a single byte 'R' is followed by 8'h0A.
